// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - operand/result bundle between operand source, serial adder and result consumer
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder, one full-adder cell and a carry flop, LSB first
module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s;
  logic             fa_c;
  logic             last_bit;

  assign fa_s     = op_a_q[0] ^ op_b_q[0] ^ carry_q;
  assign fa_c     = (op_a_q[0] & op_b_q[0]) | (carry_q & (op_a_q[0] ^ op_b_q[0]));
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          op_a_d  = bus.a;
          op_b_d  = bus.b;
          carry_d = bus.cin;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        op_a_d  = op_a_q >> 1;
        op_b_d  = op_b_q >> 1;
        // each new sum bit enters at the MSB, so after WIDTH shifts bit 0 sits at the LSB
        acc_d   = (acc_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
        carry_d = fa_c;
        cnt_d   = cnt_q + CW'(1);
        if (last_bit) begin
          state_d = IDLE;
          sum_d   = acc_d;
          cout_d  = fa_c;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == RUN);
    bus.done = done_q;
    bus.sum  = sum_q;
    bus.cout = cout_q;
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder at WIDTH 8, 4 and 1
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   done_cyc[5];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 0) ? 8 : ((g == 1) ? 4 : 1);
    serial_adder_if #(.WIDTH(W)) bus ();
    serial_adder #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [W:0] exp_q[$];
    logic [W:0] last_res = '0;
    int         m_cnt = 0;
    logic       m_done = 1'b0;

    // reference timing model: accept only when idle, WIDTH busy cycles, done on the last one
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        exp_q.delete();
        m_cnt    = 0;
        m_done   = 1'b0;
        last_res = '0;
      end else begin
        m_done = 1'b0;
        if (m_cnt != 0) begin
          m_cnt--;
          if (m_cnt == 0) m_done = 1'b1;
        end else if (bus.start) begin
          exp_q.push_back({1'b0, bus.a} + {1'b0, bus.b} + {{W{1'b0}}, bus.cin});
          m_cnt = W;
        end
      end
    end

    always @(negedge clk) begin
      if (!rst) begin
        check($sformatf("w%0d_busy", W), 32'(bus.busy), 32'(m_cnt != 0));
        check($sformatf("w%0d_done", W), 32'(bus.done), 32'(m_done));
        if (bus.done) begin
          if (exp_q.size() == 0) check($sformatf("w%0d_done_unexpected", W), 32'd1, 32'd0);
          else last_res = exp_q.pop_front();
        end
        check($sformatf("w%0d_result", W), 32'({bus.cout, bus.sum}), 32'(last_res));
      end
    end
  end

  task automatic drive(input int g, input logic s, input logic [7:0] a, input logic [7:0] b, input logic c);
    case (g)
      0: begin
        g_dut[0].bus.start = s; g_dut[0].bus.a = a; g_dut[0].bus.b = b; g_dut[0].bus.cin = c;
      end
      1: begin
        g_dut[1].bus.start = s; g_dut[1].bus.a = a[3:0]; g_dut[1].bus.b = b[3:0]; g_dut[1].bus.cin = c;
      end
      default: begin
        g_dut[2].bus.start = s; g_dut[2].bus.a = a[0]; g_dut[2].bus.b = b[0]; g_dut[2].bus.cin = c;
      end
    endcase
  endtask

  function automatic logic done_of(input int g);
    case (g)
      0:       return g_dut[0].bus.done;
      1:       return g_dut[1].bus.done;
      default: return g_dut[2].bus.done;
    endcase
  endfunction

  task automatic wait_done(input int g);
    int n = 0;
    while (!done_of(g) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check($sformatf("done_timeout_g%0d", g), 32'd0, 32'd1);
  endtask

  task automatic run_add(input int g, input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clk);
    drive(g, 1'b1, a, b, c);
    @(negedge clk);
    drive(g, 1'b0, a, b, c);
    wait_done(g);
  endtask

  initial begin
    int nb;
    for (int g = 0; g < 3; g++) drive(g, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(g_dut[0].bus.busy), 32'd0);
    check("rst_done", 32'(g_dut[0].bus.done), 32'd0);
    check("rst_sum", 32'(g_dut[0].bus.sum), 32'd0);
    check("rst_cout", 32'(g_dut[0].bus.cout), 32'd0);

    // 0F + 01: busy exactly 8 cycles, then done with 10
    @(negedge clk);
    drive(0, 1'b1, 8'h0F, 8'h01, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 8'h0F, 8'h01, 1'b0);
    nb = 0;
    while (g_dut[0].bus.busy && nb < 20) begin
      nb++;
      @(negedge clk);
    end
    check("t1_busy_cycles", 32'(nb), 32'd8);
    check("t1_done", 32'(g_dut[0].bus.done), 32'd1);
    check("t1_sum", 32'(g_dut[0].bus.sum), 32'h10);
    check("t1_cout", 32'(g_dut[0].bus.cout), 32'd0);

    run_add(0, 8'hFF, 8'h01, 1'b0);
    check("t2_sum", 32'(g_dut[0].bus.sum), 32'h00);
    check("t2_cout", 32'(g_dut[0].bus.cout), 32'd1);
    run_add(0, 8'hFF, 8'hFF, 1'b1);
    check("t3_sum", 32'(g_dut[0].bus.sum), 32'hFF);
    check("t3_cout", 32'(g_dut[0].bus.cout), 32'd1);

    // start and operands churn every cycle; only idle-time starts count
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      drive(0, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
    end
    @(negedge clk);
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (12) @(negedge clk);
    check("rand_drain", 32'(g_dut[0].exp_q.size()), 32'd0);

    // asynchronous abort three cycles into a run
    @(negedge clk);
    drive(0, 1'b1, 8'hC3, 8'h5A, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 8'hC3, 8'h5A, 1'b1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 32'(g_dut[0].bus.busy), 32'd0);
    check("abort_done", 32'(g_dut[0].bus.done), 32'd0);
    check("abort_sum", 32'(g_dut[0].bus.sum), 32'd0);
    check("abort_cout", 32'(g_dut[0].bus.cout), 32'd0);
    #5 rst = 1'b0;
    run_add(0, 8'hA5, 8'h3C, 1'b0);
    check("after_abort_sum", 32'(g_dut[0].bus.sum), 32'hE1);
    check("after_abort_cout", 32'(g_dut[0].bus.cout), 32'd0);

    // start held high: one result every WIDTH+1 cycles
    @(negedge clk);
    drive(0, 1'b1, 8'h7A, 8'h9B, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      wait_done(0);
      done_cyc[i] = cyc;
      if (i == 4) drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
      else drive(0, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
    end
    for (int i = 1; i < 5; i++) check($sformatf("gap_%0d", i), 32'(done_cyc[i] - done_cyc[i-1]), 32'd9);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          run_add(1, 8'(a), 8'(b), 1'(c));

    for (int i = 0; i < 8; i++) run_add(2, 8'(i & 1), 8'((i >> 1) & 1), 1'(i >> 2));

    repeat (12) @(negedge clk);
    check("w8_sb_empty", 32'(g_dut[0].exp_q.size()), 32'd0);
    check("w4_sb_empty", 32'(g_dut[1].exp_q.size()), 32'd0);
    check("w1_sb_empty", 32'(g_dut[2].exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial N-bit adder built around a single full-adder cell and a carry flip-flop. It accepts two parallel operands and a carry-in on a start strobe, and adds them LSB-first, one bit per clock. It presents the registered WIDTH-bit sum and carry-out with a one-cycle done pulse. It sits directly downstream of the operand source and is the area-minimal alternative to a ripple chain of full adders, feeding the result consumer.

## Interface
- WIDTH, 8: operand/sum width in bits; legal range ≥ 1.
- clk  in  1  rising-edge clock; sole clock domain.
- rst  in  1  asynchronous, active-high reset; clears all state immediately.
- start  in  1  request; sampled only while idle.
- a  in  WIDTH  operand A; captured on accepted start.
- b  in  WIDTH  operand B; captured on accepted start.
- cin  in  1  carry-in; captured on accepted start.
- busy  out  1  high while an addition is in progress.
- done  out  1  one-cycle pulse; result valid and newly updated.
- sum  out  WIDTH  registered result a+b+cin, low WIDTH bits.
- cout  out  1  registered carry-out, bit WIDTH of a+b+cin.

## Operation
- One clock, clk. Reset is asynchronous and active-high on rst.
- Reset values: busy=0, done=0, sum=0, cout=0, state=IDLE, internal shift registers, carry and counter all 0.
- FSM states:
  - IDLE: busy=0. If start=1 at an edge, it loads a, b, cin into opA/opB/carry shift state, clears the bit counter and moves to RUN.
  - RUN: busy=1. Each edge, it computes s = opA[0]^opB[0]^carry and c = opA[0]&opB[0] | carry&(opA[0]^opB[0]). It shifts s into the MSB of the internal sum shift register, shifts opA/opB right by one, sets carry=c and increments the counter.
  - Last bit: on the edge processing bit WIDTH-1, sum and cout load the final shift-register value and carry, done=1, and the state returns to IDLE.
- done is high for exactly one cycle per completed addition. Otherwise done=0.
- sum/cout change only on the done edge. They hold the previous result throughout RUN and IDLE.
- start while busy=1 is ignored; no queuing. Changes on a/b/cin after acceptance have no effect.
- Counter width is clog2(WIDTH+1). Arithmetic is unsigned, and {cout,sum} equals a+b+cin exactly for all inputs.
- rst asserted mid-operation: it aborts immediately, all outputs are forced to reset values and the partial result is discarded. There is no done pulse for the aborted addition.

## Timing
- start=1 sampled at edge k while IDLE: busy rises after edge k.
- Bits 0..WIDTH-1 are processed at edges k+1..k+WIDTH.
- At edge k+WIDTH: sum/cout are updated, done=1 and busy=0, held for one cycle.
- Latency from accepting edge to result is WIDTH edges. busy is high for exactly WIDTH cycles.
- The earliest next accept is edge k+WIDTH+1. done=1 coincides with IDLE, so start high during the done cycle is accepted at that edge.
- With start held high continuously, the throughput is one addition per WIDTH+1 cycles.
- rst takes effect without a clock edge. The first start is accepted at the first rising edge after rst deasserts.

## Test plan
- WIDTH=8, a=8'h0F, b=8'h01, cin=0, start pulsed at edge k → busy high 8 cycles; at edge k+8 done=1, sum=8'h10, cout=0.
- WIDTH=8, a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 → sum=8'hFF, cout=1, with sum holding 8'h00 throughout the second RUN.
- start pulsed, and a/b toggled to random values, on every cycle while busy → exactly one done per accepted start. The result matches the operands captured at acceptance.
- rst asserted asynchronously 3 cycles into a RUN → busy/done/sum/cout=0 immediately with no done pulse. The next start after release gives the correct result at WIDTH edges.
- start held high continuously for 5 additions, WIDTH=8 → done pulses spaced exactly 9 cycles apart, each result correct.
- WIDTH=4 exhaustive: all 512 (a,b,cin) combinations → {cout,sum}==a+b+cin for every case. WIDTH=1 is smoke-tested with all 8 combinations.
